// File: rtl/hash_top.sv
// Key-hashing stage: pops a key length and its 128-bit key words, runs an FNV-1a style
// 32-bit mix, and queues the packed {h1,h2,h3} result in an internal FWFT output FIFO.
module hash_top #(
  parameter int unsigned FIFOWIDTH     = 128,
  parameter int unsigned KEYHASH_WIDTH = 57,
  parameter int unsigned OUT_DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     oRdKeyClk,
  input  logic                     iRdKeyEmpty,
  input  logic                     iRdKeyLenEmpty,
  output logic                     oRdKeyFifo_en,
  output logic                     oRdKeyLenFifo_en,
  input  logic [FIFOWIDTH-1:0]     iKey,
  input  logic [7:0]               iKeyLen,
  output logic                     oRdHashEmpty,
  input  logic                     iRdHashFifo_en,
  output logic [KEYHASH_WIDTH-1:0] oKeyHashFifo
);

  localparam int unsigned AW        = $clog2(OUT_DEPTH);
  localparam logic [31:0] FNV_BASIS = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME = 32'h01000193;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MIX, S_FINAL, S_PUSH} state_t;
  state_t r_state, w_next;

  logic [7:0]               r_len;
  logic [4:0]               r_words;
  logic [1:0]               r_lane;
  logic [31:0]              r_h;
  logic [FIFOWIDTH-1:0]     r_word;
  logic                     r_key_pop, r_len_pop;
  logic [AW:0]              r_wr_ptr, r_rd_ptr;
  logic [KEYHASH_WIDTH-1:0] r_mem [OUT_DEPTH];

  logic                     w_take_len, w_take_key, w_mix, w_final, w_push;
  logic                     w_full, w_empty, w_pop;
  logic [4:0]               w_words;
  logic [FIFOWIDTH-1:0]     w_masked;
  logic [31:0]              w_lane_word, w_mix_h, w_final_h;
  logic [23:0]              w_h2;
  logic [4:0]               w_h3;
  logic [KEYHASH_WIDTH-1:0] w_packed;

  assign oRdKeyClk = clk;

  // Full/empty come from registered pointers, so a same-cycle pop cannot unblock a push.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = iRdHashFifo_en && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!iRdKeyLenEmpty) w_next = (iKeyLen == 8'd0) ? S_FINAL : S_LOAD;
      S_LOAD:  if (!iRdKeyEmpty) w_next = S_MIX;
      S_MIX:   if (r_lane == 2'd3) w_next = (r_words == 5'd1) ? S_FINAL : S_LOAD;
      S_FINAL: w_next = S_PUSH;
      S_PUSH:  if (!w_full) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_take_len = (r_state == S_IDLE) && !iRdKeyLenEmpty;
    w_take_key = (r_state == S_LOAD) && !iRdKeyEmpty;
    w_mix      = (r_state == S_MIX);
    w_final    = (r_state == S_FINAL);
    w_push     = (r_state == S_PUSH) && !w_full;
  end

  assign w_words = {1'b0, iKeyLen[7:4]} + {4'd0, |iKeyLen[3:0]};

  // Bytes beyond the key length in the final word must not affect the hash.
  always_comb begin
    w_masked = '0;
    for (int unsigned i = 0; i < FIFOWIDTH / 8; i++) begin
      if (r_words != 5'd1 || r_len[3:0] == 4'd0 || 4'(i) < r_len[3:0])
        w_masked[8*i +: 8] = iKey[8*i +: 8];
    end
  end

  assign w_lane_word = r_word[{r_lane, 5'd0} +: 32];
  assign w_mix_h     = (r_h ^ w_lane_word) * FNV_PRIME;
  assign w_final_h   = (r_h ^ {24'd0, r_len}) * FNV_PRIME;

  assign w_h2     = r_h[31:8] ^ {r_h[7:0], r_h[31:16]};
  assign w_h3     = r_h[4:0] ^ r_h[9:5] ^ r_h[14:10] ^ r_h[19:15] ^ r_h[24:20] ^ r_h[29:25];
  assign w_packed = {r_h[27:0], w_h2, w_h3};

  // Pops are registered so they are 0 in reset; the heads are not re-sampled before they retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len     <= '0;
      r_words   <= '0;
      r_lane    <= '0;
      r_h       <= FNV_BASIS;
      r_word    <= '0;
      r_key_pop <= 1'b0;
      r_len_pop <= 1'b0;
    end else begin
      r_key_pop <= w_take_key;
      r_len_pop <= w_take_len;
      if (w_take_len) begin
        r_len   <= iKeyLen;
        r_words <= w_words;
        r_h     <= FNV_BASIS;
      end
      if (w_take_key) begin
        r_word <= w_masked;
        r_lane <= '0;
      end
      if (w_mix) begin
        r_h    <= w_mix_h;
        r_lane <= r_lane + 2'd1;
        if (r_lane == 2'd3) r_words <= r_words - 5'd1;
      end
      if (w_final) r_h <= w_final_h;
    end
  end

  assign oRdKeyFifo_en    = r_key_pop;
  assign oRdKeyLenFifo_en = r_len_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_packed;
  end

  assign oRdHashEmpty = w_empty;
  assign oKeyHashFifo = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_hash_top.sv
// Randomized bench for hash_top: models the upstream FWFT FIFOs with queues and checks every
// output against a byte-level FNV-1a reference computed from the key contents.
module tb_hash_top;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_clk;
  logic         iRdKeyEmpty = 1'b1;
  logic         iRdKeyLenEmpty = 1'b1;
  logic         oRdKeyFifo_en, oRdKeyLenFifo_en;
  logic [127:0] iKey = '0;
  logic [7:0]   iKeyLen = '0;
  logic         oRdHashEmpty;
  logic         iRdHashFifo_en = 1'b0;
  logic [56:0]  oKeyHashFifo;

  hash_top #(.FIFOWIDTH(128), .KEYHASH_WIDTH(57), .OUT_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .oRdKeyClk(key_clk),
    .iRdKeyEmpty(iRdKeyEmpty), .iRdKeyLenEmpty(iRdKeyLenEmpty),
    .oRdKeyFifo_en(oRdKeyFifo_en), .oRdKeyLenFifo_en(oRdKeyLenFifo_en),
    .iKey(iKey), .iKeyLen(iKeyLen),
    .oRdHashEmpty(oRdHashEmpty), .iRdHashFifo_en(iRdHashFifo_en),
    .oKeyHashFifo(oKeyHashFifo)
  );

  always #5 clk = ~clk;

  logic [7:0]   len_q[$];
  logic [127:0] key_q[$];
  logic [56:0]  exp_q[$];
  logic [56:0]  out_log[$];
  int           lpop_t[$];
  int           w_list[$];
  logic [7:0]   kb[256];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, l_pops = 0, k_pops = 0, bad_pops = 0, outs = 0;
  int man_req = 0, man_done = 0;
  bit auto_pop = 0, rand_pop = 0, gap_mode = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [56:0] model(input int len, input logic [7:0] kbytes[256]);
    logic [31:0] h, v;
    logic [23:0] h2;
    logic [4:0]  h3;
    int          nw;
    h  = 32'h811C9DC5;
    nw = (len + 15) / 16;
    for (int w = 0; w < nw; w++) begin
      for (int l = 0; l < 4; l++) begin
        v = '0;
        for (int b = 0; b < 4; b++)
          if (16*w + 4*l + b < len) v[8*b +: 8] = kbytes[16*w + 4*l + b];
        h = (h ^ v) * 32'h01000193;
      end
    end
    h  = (h ^ 32'(len)) * 32'h01000193;
    h2 = h[31:8] ^ {h[7:0], h[31:16]};
    h3 = h[4:0] ^ h[9:5] ^ h[14:10] ^ h[19:15] ^ h[24:20] ^ h[29:25];
    return {h[27:0], h2, h3};
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) kb[i] = 8'($urandom);
  endtask

  // Bytes past the length carry random junk; the reference ignores them.
  task automatic send_key(input int len);
    logic [127:0] word;
    int nw;
    nw = (len + 15) / 16;
    for (int w = 0; w < nw; w++) begin
      for (int i = 0; i < 16; i++)
        word[8*i +: 8] = (16*w + i < len) ? kb[16*w + i] : 8'($urandom);
      key_q.push_back(word);
    end
    len_q.push_back(8'(len));
    exp_q.push_back(model(len, kb));
    w_list.push_back(nw);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (!(len_q.size() == 0 && key_q.size() == 0 && exp_q.size() == 0 && oRdHashEmpty)
           && c < budget) begin
      tick(1);
      c++;
    end
    chk("drain_in_time", 64'(c < budget), 64'd1);
    tick(5);
  endtask

  // Upstream FIFO and downstream reader models; all updates land mid-cycle.
  always @(negedge clk) begin : env
    logic [56:0] e;
    bit do_pop;
    cyc++;
    if (oRdKeyLenFifo_en) begin
      if (len_q.size() == 0) bad_pops++;
      else void'(len_q.pop_front());
      l_pops++;
      lpop_t.push_back(cyc);
    end
    if (oRdKeyFifo_en) begin
      if (key_q.size() == 0) bad_pops++;
      else void'(key_q.pop_front());
      k_pops++;
    end
    iRdKeyLenEmpty = (len_q.size() == 0) || (gap_mode && $urandom_range(0, 3) == 0);
    iKeyLen        = (len_q.size() != 0) ? len_q[0] : 8'd0;
    iRdKeyEmpty    = (key_q.size() == 0) || (gap_mode && $urandom_range(0, 3) == 0);
    iKey           = (key_q.size() != 0) ? key_q[0] : '0;
    if (rand_pop) do_pop = ($urandom_range(0, 1) == 1);
    else if (man_req != man_done) begin
      do_pop = 1'b1;
      man_done++;
    end else do_pop = auto_pop && !oRdHashEmpty;
    iRdHashFifo_en = do_pop;
    if (do_pop && !oRdHashEmpty) begin
      if (exp_q.size() == 0) chk("extra_output", 64'(oKeyHashFifo), 64'd0 - 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("hash_word", 64'(oKeyHashFifo), 64'(e));
      end
      out_log.push_back(oKeyHashFifo);
      outs++;
    end
  end

  int blens[4] = '{16, 17, 255, 32};
  int bwrds[4] = '{1, 2, 16, 2};

  initial begin : main
    int bl, bk, bo, bt, bw;
    tick(3);
    chk("rst_empty", 64'(oRdHashEmpty), 64'd1);
    chk("rst_keypop", 64'(oRdKeyFifo_en), 64'd0);
    chk("rst_lenpop", 64'(oRdKeyLenFifo_en), 64'd0);
    chk("rst_head", 64'(oKeyHashFifo), 64'd0);
    rst = 1'b1;
    tick(10);
    chk("idle_empty", 64'(oRdHashEmpty), 64'd1);
    chk("idle_pops", 64'(l_pops + k_pops), 64'd0);

    auto_pop = 1'b1;
    bl = l_pops; bk = k_pops;
    len_q.push_back(8'd0);
    exp_q.push_back({28'h50C5D1F, 24'h1A0951, 5'h0A});
    w_list.push_back(0);
    wait_drain(100);
    chk("len0_lenpops", 64'(l_pops - bl), 64'd1);
    chk("len0_keypops", 64'(k_pops - bk), 64'd0);

    for (int i = 0; i < 4; i++) begin
      bl = l_pops; bk = k_pops;
      fill_rand();
      send_key(blens[i]);
      wait_drain(300);
      chk("bnd_lenpops", 64'(l_pops - bl), 64'd1);
      chk("bnd_keypops", 64'(k_pops - bk), 64'(bwrds[i]));
    end

    fill_rand();
    send_key(5);
    send_key(5);
    wait_drain(200);
    chk("mask_equal", 64'(out_log[out_log.size()-1]), 64'(out_log[out_log.size()-2]));

    bt = lpop_t.size(); bw = w_list.size(); bo = outs;
    for (int i = 0; i < 4; i++) begin
      fill_rand();
      send_key($urandom_range(0, 80));
    end
    wait_drain(800);
    chk("b2b_outs", 64'(outs - bo), 64'd4);
    for (int i = 0; i < 3; i++)
      chk("b2b_spacing", 64'(lpop_t[bt+i+1] - lpop_t[bt+i]), 64'(3 + 5 * w_list[bw+i]));

    auto_pop = 1'b0;
    bl = l_pops; bo = outs;
    for (int i = 0; i < 18; i++) begin
      fill_rand();
      send_key($urandom_range(0, 31));
    end
    tick(400);
    chk("bp_stall_lenpops", 64'(l_pops - bl), 64'd17);
    chk("bp_not_empty", 64'(oRdHashEmpty), 64'd0);
    man_req++;
    tick(10);
    chk("bp_resume_lenpops", 64'(l_pops - bl), 64'd18);
    auto_pop = 1'b1;
    wait_drain(600);
    chk("bp_outs", 64'(outs - bo), 64'd18);

    gap_mode = 1'b1; rand_pop = 1'b1; bo = outs;
    for (int i = 0; i < 30; i++) begin
      fill_rand();
      send_key($urandom_range(0, 255));
    end
    wait_drain(12000);
    gap_mode = 1'b0; rand_pop = 1'b0;
    tick(3);
    chk("rand_outs", 64'(outs - bo), 64'd30);

    bo = outs;
    fill_rand();
    send_key(200);
    tick(25);
    rst = 1'b0;
    len_q.delete(); key_q.delete(); exp_q.delete();
    tick(2);
    rst = 1'b1;
    tick(100);
    chk("rstmid_empty", 64'(oRdHashEmpty), 64'd1);
    chk("rstmid_outs", 64'(outs - bo), 64'd0);
    fill_rand();
    send_key($urandom_range(1, 40));
    wait_drain(300);
    chk("rstmid_after_outs", 64'(outs - bo), 64'd1);

    chk("no_empty_pops", 64'(bad_pops), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
